pc_unit_ras: RTL and testbench

Sequential PC controller for the CPU fetch stage.
- Owns the program counter register.
- Resolves branch, jump, call and return each cycle.
- Keeps a parametrised circular return-address stack (RAS) for call/return.
- Produces the next fetch address and a redirect flag for pipeline flush, with sticky overflow/underflow error flags.

---
 rtl/pc_unit_ras.sv | 167 ++++++++++++++++
 tb/tb_pc_unit_ras.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit_ras.sv
// Fetch-stage PC controller: resolves ret/call/jump/branch each cycle and keeps
// a circular return-address stack with sticky overflow/underflow flags.
module pc_unit_ras #(
   parameter int unsigned        ADDR_W    = 16,
   parameter int unsigned        RAS_DEPTH = 8,
   parameter logic [ADDR_W-1:0]  RESET_PC  = '0
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 stall,
   input  logic                                 branch,
   input  logic                                 jump,
   input  logic                                 call,
   input  logic                                 ret,
   input  logic [2:0]                           condition_code,
   input  logic [2:0]                           condition_flags,
   input  logic [ADDR_W-1:0]                    branch_offset,
   input  logic [ADDR_W-1:0]                    jump_offset,
   input  logic                                 clr_err,
   output logic [ADDR_W-1:0]                    PC,
   output logic [ADDR_W-1:0]                    PC_plus_one,
   output logic [ADDR_W-1:0]                    PC_next,
   output logic                                 PC_select,
   output logic [$clog2(RAS_DEPTH+1)-1:0]       ras_count,
   output logic                                 ras_overflow,
   output logic                                 ras_underflow
);

   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

   localparam logic [2:0] CC_U   = 3'd0;
   localparam logic [2:0] CC_EQ  = 3'd1;
   localparam logic [2:0] CC_NE  = 3'd2;
   localparam logic [2:0] CC_GT  = 3'd3;
   localparam logic [2:0] CC_GTE = 3'd4;
   localparam logic [2:0] CC_LT  = 3'd5;
   localparam logic [2:0] CC_LTE = 3'd6;
   localparam logic [2:0] CC_OF  = 3'd7;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];

   logic              flag_z, flag_n, flag_v;
   logic              cond_true;
   logic              ras_empty, ras_full;
   logic [ADDR_W-1:0] ras_top;
   logic [ADDR_W-1:0] pc_inc;
   logic              push_req, pop_req, unf_evt, ovf_evt;
   logic              ras_we;
   logic [PTR_W-1:0]  ras_waddr;

   assign flag_z = condition_flags[2];
   assign flag_n = condition_flags[1];
   assign flag_v = condition_flags[0];

   // Branch condition decode
   always_comb begin
      cond_true = 1'b0;
      case (condition_code)
         CC_U:    cond_true = 1'b1;
         CC_EQ:   cond_true = flag_z;
         CC_NE:   cond_true = ~flag_z;
         CC_GT:   cond_true = ~flag_z & ~flag_n;
         CC_GTE:  cond_true = ~flag_n;
         CC_LT:   cond_true = flag_n;
         CC_LTE:  cond_true = flag_z | flag_n;
         CC_OF:   cond_true = flag_v;
         default: cond_true = 1'b0;
      endcase
   end

   assign pc_inc    = pc_q + ADDR_W'(1);
   assign ras_empty = (count_q == '0);
   assign ras_full  = (count_q == CNT_W'(RAS_DEPTH));
   assign ras_top   = ras_mem_q[ptr_q];

   // Control-flow resolution, priority ret > call > jump > branch > sequential
   always_comb begin
      PC_next   = pc_inc;
      PC_select = 1'b0;
      push_req  = 1'b0;
      pop_req   = 1'b0;
      unf_evt   = 1'b0;
      if (ret) begin
         if (!ras_empty) begin
            pop_req   = 1'b1;
            PC_next   = ras_top;
            PC_select = 1'b1;
         end else begin
            unf_evt = 1'b1;
         end
      end else if (call) begin
         push_req  = 1'b1;
         PC_next   = pc_inc + jump_offset;
         PC_select = 1'b1;
      end else if (jump) begin
         PC_next   = pc_inc + jump_offset;
         PC_select = 1'b1;
      end else if (branch && cond_true) begin
         PC_next   = pc_inc + branch_offset;
         PC_select = 1'b1;
      end
   end

   assign ovf_evt = push_req & ras_full;

   // Next-state for PC, stack pointer, count and sticky flags; stall freezes all
   always_comb begin
      pc_d      = pc_q;
      ptr_d     = ptr_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      ras_we    = 1'b0;
      ras_waddr = ptr_q + PTR_W'(1);
      if (!stall) begin
         pc_d  = PC_next;
         ovf_d = ovf_evt | (ovf_q & ~clr_err);
         unf_d = unf_evt | (unf_q & ~clr_err);
         if (push_req) begin
            ras_we = 1'b1;
            ptr_d  = ptr_q + PTR_W'(1);
            if (!ras_full) begin
               count_d = count_q + CNT_W'(1);
            end
         end else if (pop_req) begin
            ptr_d   = ptr_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         ptr_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Stack storage needs no reset; validity is tracked by count_q
   always_ff @(posedge clk) begin
      if (ras_we) begin
         ras_mem_q[ras_waddr] <= pc_inc;
      end
   end

   assign PC            = pc_q;
   assign PC_plus_one   = pc_inc;
   assign ras_count     = count_q;
   assign ras_overflow  = ovf_q;
   assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Scoreboard bench for pc_unit_ras: a queue-based LIFO model predicts every
// registered outcome; combinational decision outputs are checked before each edge.
module tb_pc_unit_ras;

   localparam int unsigned ADDR_W    = 16;
   localparam int unsigned RAS_DEPTH = 8;
   localparam int unsigned CNT_W     = 4;
   localparam logic [15:0] RST_PC    = 16'h0000;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              stall, branch, jump, call, ret, clr_err;
   logic [2:0]        condition_code, condition_flags;
   logic [15:0]       branch_offset, jump_offset;
   logic [15:0]       PC, PC_plus_one, PC_next;
   logic              PC_select;
   logic [CNT_W-1:0]  ras_count;
   logic              ras_overflow, ras_underflow;

   typedef struct {
      logic [15:0]      pc;
      logic [CNT_W-1:0] cnt;
      logic             ovf;
      logic             unf;
   } exp_t;

   exp_t        sb_q[$];
   logic [15:0] m_stk[$];
   logic [15:0] m_pc;
   logic        m_ovf, m_unf;
   int          n_cmp = 0;
   int          n_err = 0;

   pc_unit_ras #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .jump(jump),
      .call(call), .ret(ret), .condition_code(condition_code),
      .condition_flags(condition_flags), .branch_offset(branch_offset),
      .jump_offset(jump_offset), .clr_err(clr_err), .PC(PC),
      .PC_plus_one(PC_plus_one), .PC_next(PC_next), .PC_select(PC_select),
      .ras_count(ras_count), .ras_overflow(ras_overflow),
      .ras_underflow(ras_underflow)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic cond_model(input logic [2:0] cc, input logic [2:0] fl);
      logic z, n, v;
      z = fl[2]; n = fl[1]; v = fl[0];
      case (cc)
         3'd0: return 1'b1;
         3'd1: return z;
         3'd2: return !z;
         3'd3: return !z && !n;
         3'd4: return !n;
         3'd5: return n;
         3'd6: return z || n;
         default: return v;
      endcase
   endfunction

   // One cycle: drive at negedge, check decision, predict, compare after the edge
   task automatic step(input logic st, input logic br, input logic jp, input logic cl,
                       input logic rt, input logic [2:0] cc, input logic [2:0] fl,
                       input logic [15:0] bo, input logic [15:0] jo, input logic clr);
      logic [15:0] ppo, nxt;
      logic        sel, ovf_evt, unf_evt;
      exp_t        e, g;
      stall = st; branch = br; jump = jp; call = cl; ret = rt;
      condition_code = cc; condition_flags = fl;
      branch_offset = bo; jump_offset = jo; clr_err = clr;
      ppo = m_pc + 16'd1;
      nxt = ppo;
      sel = 1'b0;
      ovf_evt = 1'b0;
      unf_evt = 1'b0;
      if (rt) begin
         if (m_stk.size() > 0) begin
            nxt = m_stk[m_stk.size() - 1];
            sel = 1'b1;
         end else begin
            unf_evt = 1'b1;
         end
      end else if (cl) begin
         nxt = ppo + jo;
         sel = 1'b1;
         ovf_evt = (m_stk.size() == RAS_DEPTH);
      end else if (jp || (br && cond_model(cc, fl))) begin
         nxt = ppo + (jp ? jo : bo);
         sel = 1'b1;
      end
      #1;
      check_eq("pc_plus_one", 32'(PC_plus_one), 32'(ppo));
      check_eq("pc_next", 32'(PC_next), 32'(nxt));
      check_eq("pc_select", 32'(PC_select), 32'(sel));
      if (!st) begin
         if (rt && m_stk.size() > 0) begin
            void'(m_stk.pop_back());
         end else if (cl && !rt) begin
            m_stk.push_back(ppo);
            if (m_stk.size() > RAS_DEPTH) void'(m_stk.pop_front());
         end
         m_ovf = ovf_evt | (m_ovf & !clr);
         m_unf = unf_evt | (m_unf & !clr);
         m_pc  = nxt;
      end
      e.pc = m_pc; e.cnt = CNT_W'(m_stk.size()); e.ovf = m_ovf; e.unf = m_unf;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         n_cmp++; n_err++;
         $display("FAIL scoreboard: queue empty, got 0 entries expected 1");
      end else begin
         g = sb_q.pop_front();
         check_eq("pc", 32'(PC), 32'(g.pc));
         check_eq("ras_count", 32'(ras_count), 32'(g.cnt));
         check_eq("ras_overflow", 32'(ras_overflow), 32'(g.ovf));
         check_eq("ras_underflow", 32'(ras_underflow), 32'(g.unf));
      end
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 1'b0);
   endtask

   task automatic goto(input logic [15:0] target);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0, target - (m_pc + 16'd1), 1'b0);
   endtask

   task automatic do_call(input logic [15:0] jo);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 16'h0, jo, 1'b0);
   endtask

   task automatic do_ret();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 16'h0, 16'h0, 1'b0);
   endtask

   task automatic model_reset();
      m_pc = RST_PC; m_ovf = 1'b0; m_unf = 1'b0;
      m_stk.delete();
      sb_q.delete();
   endtask

   initial begin
      rst_n = 1'b0;
      stall = 0; branch = 0; jump = 0; call = 0; ret = 0; clr_err = 0;
      condition_code = '0; condition_flags = '0;
      branch_offset = '0; jump_offset = '0;
      model_reset();
      #3;
      check_eq("reset_pc", 32'(PC), 32'(RST_PC));
      check_eq("reset_count", 32'(ras_count), 32'd0);
      check_eq("reset_ovf", 32'(ras_overflow), 32'd0);
      check_eq("reset_unf", 32'(ras_underflow), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Sequential wrap from the top of the address space
      goto(16'hFFFF);
      idle();
      check_eq("wrap_pc", 32'(PC), 32'h0000);

      // Branch taken / not taken and full condition sweep
      goto(16'h0010);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0004, 16'h0, 1'b0);
      check_eq("br_taken_pc", 32'(PC), 32'h0015);
      goto(16'h0010);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 16'h0004, 16'h0, 1'b0);
      check_eq("br_not_taken_pc", 32'(PC), 32'h0011);
      for (int c = 0; c < 8; c++) begin
         for (int f = 0; f < 8; f++) begin
            goto(16'h0010);
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'(c), 3'(f), 16'h0004, 16'h0, 1'b0);
         end
      end

      // Simple call / return
      goto(16'h0100);
      do_call(16'h0100);
      check_eq("call_pc", 32'(PC), 32'h0201);
      do_ret();
      check_eq("ret_pc", 32'(PC), 32'h0101);

      // Overflow with 9 nested calls, LIFO unwind, then underflow and clear
      for (int i = 0; i < 9; i++) do_call(16'h0010);
      check_eq("ovf_count", 32'(ras_count), 32'd8);
      check_eq("ovf_flag", 32'(ras_overflow), 32'd1);
      for (int i = 0; i < 8; i++) do_ret();
      do_ret();
      check_eq("unf_flag", 32'(ras_underflow), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 1'b1);
      check_eq("clr_ovf", 32'(ras_overflow), 32'd0);
      check_eq("clr_unf", 32'(ras_underflow), 32'd0);

      // Priority: ret beats call and branch, and no push happens
      goto(16'h0041);
      do_call(16'h0300);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 16'h0008, 16'h0100, 1'b0);
      check_eq("prio_pc", 32'(PC), 32'h0042);
      check_eq("prio_count", 32'(ras_count), 32'd0);

      // Stall holds a pending jump for three cycles
      goto(16'h0200);
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 16'h0050, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 16'h0050, 1'b0);
      check_eq("stall_release_pc", 32'(PC), 32'h0251);

      // Randomised mix of all controls
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 5) == 0, ($urandom % 2) == 0, ($urandom % 6) == 0,
              ($urandom % 4) == 0, ($urandom % 4) == 0, 3'($urandom), 3'($urandom),
              16'($urandom), 16'($urandom), ($urandom % 8) == 0);
      end

      // Asynchronous reset between edges after three calls
      for (int i = 0; i < 3; i++) do_call(16'h0020);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_pc", 32'(PC), 32'(RST_PC));
      check_eq("async_rst_count", 32'(ras_count), 32'd0);
      check_eq("async_rst_ovf", 32'(ras_overflow), 32'd0);
      check_eq("async_rst_unf", 32'(ras_underflow), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      do_ret();
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
